// File: rtl/bcd_tens_scan_display_if.sv
// -----------------------------------------------------------------------------
// bcd_tens_scan_display_if
// Bundle between the decade ones counter / board and the tens-digit display
// block.
//   ones_bcd  : ones digit from the upstream decade counter (0-9 legal)
//   tens_bcd  : registered tens digit (0-9)
//   carry_out : one-cycle pulse when the tens digit wraps 9->0
//   an        : digit anodes, active-low, an[0]=ones, an[1]=tens
//   seg       : segments {g,f,e,d,c,b,a}, active-low
// Modports:
//   master : upstream/board side, drives ones_bcd and observes the display
//   slave  : display block side
// -----------------------------------------------------------------------------
interface bcd_tens_scan_display_if;
   logic [3:0] ones_bcd;
   logic [3:0] tens_bcd;
   logic       carry_out;
   logic [1:0] an;
   logic [6:0] seg;

   modport master (
      output ones_bcd,
      input  tens_bcd,
      input  carry_out,
      input  an,
      input  seg
   );

   modport slave (
      input  ones_bcd,
      output tens_bcd,
      output carry_out,
      output an,
      output seg
   );
endinterface

// File: rtl/bcd_tens_scan_display.sv
// -----------------------------------------------------------------------------
// bcd_tens_scan_display
// Watches the BCD ones digit of an upstream decade counter, advances a
// cascaded tens digit on every 9->0 roll-over of the ones digit, and
// time-multiplexes both digits onto a 2-digit common-anode 7-segment display.
//
// Ports:
//   clk     : system clock, all logic on the rising edge
//   rst     : synchronous reset, active-low
//   io_disp : bcd_tens_scan_display_if.slave
//             (ones_bcd in; tens_bcd, carry_out, an, seg out)
//
// Parameters:
//   REFRESH_DIV : clock cycles each digit stays lit (>= 2)
//
// Optional build macro:
//   LEADING_ZERO_BLANK_EN : when defined, the tens digit is kept dark while
//                           tens_bcd==0; scan timing is unaffected.
// -----------------------------------------------------------------------------
module bcd_tens_scan_display #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic                         clk,
   input  logic                         rst,
   bcd_tens_scan_display_if.slave       io_disp
);

   localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

   typedef enum logic {
      SCAN_ONES = 1'b0,
      SCAN_TENS = 1'b1
   } scan_state_t;

   scan_state_t      r_state;
   scan_state_t      w_state_nxt;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] w_div_nxt;
   logic [3:0]       r_ones_prev;
   logic [3:0]       r_tens;
   logic [3:0]       w_tens_nxt;
   logic             r_carry;
   logic             w_carry_nxt;
   logic             w_wrap;
   logic [1:0]       r_an;
   logic [1:0]       w_an_nxt;
   logic [6:0]       r_seg;
   logic [6:0]       w_seg_nxt;

   // Active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash.
   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      logic [6:0] segs;
      case (digit)
         4'd0:    segs = 7'b1000000;
         4'd1:    segs = 7'b1111001;
         4'd2:    segs = 7'b0100100;
         4'd3:    segs = 7'b0110000;
         4'd4:    segs = 7'b0011001;
         4'd5:    segs = 7'b0010010;
         4'd6:    segs = 7'b0000010;
         4'd7:    segs = 7'b1111000;
         4'd8:    segs = 7'b0000000;
         4'd9:    segs = 7'b0010000;
         default: segs = 7'b0111111;
      endcase
      return segs;
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      w_div_nxt   = r_div + 1'b1;
      w_tens_nxt  = r_tens;
      w_carry_nxt = 1'b0;
      w_an_nxt    = 2'b11;
      w_seg_nxt   = 7'b1111111;

      // Only a true 9 followed by a true 0 counts; codes 10-15 on either
      // side break the pair, so 9->C->0 never advances the tens digit.
      w_wrap = (r_ones_prev == 4'd9) && (io_disp.ones_bcd == 4'd0);

      if (w_wrap) begin
         if (r_tens == 4'd9) begin
            w_tens_nxt  = 4'd0;
            w_carry_nxt = 1'b1;
         end else begin
            w_tens_nxt  = r_tens + 4'd1;
         end
      end

      if (r_div == DIV_LAST) begin
         w_div_nxt   = '0;
         w_state_nxt = (r_state == SCAN_ONES) ? SCAN_TENS : SCAN_ONES;
      end

      // Display is driven from the state in force before this edge, so a
      // digit stays lit for exactly REFRESH_DIV cycles.
      case (r_state)
         SCAN_ONES: begin
            w_an_nxt  = 2'b10;
            w_seg_nxt = seg_decode(io_disp.ones_bcd);
         end
         SCAN_TENS: begin
`ifdef LEADING_ZERO_BLANK_EN
            if (r_tens == 4'd0) begin
               w_an_nxt  = 2'b11;
               w_seg_nxt = 7'b1111111;
            end else begin
               w_an_nxt  = 2'b01;
               w_seg_nxt = seg_decode(r_tens);
            end
`else
            w_an_nxt  = 2'b01;
            w_seg_nxt = seg_decode(r_tens);
`endif
         end
         default: begin
            w_an_nxt  = 2'b11;
            w_seg_nxt = 7'b1111111;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= SCAN_ONES;
         r_div       <= '0;
         r_ones_prev <= 4'd0;
         r_tens      <= 4'd0;
         r_carry     <= 1'b0;
         r_an        <= 2'b11;
         r_seg       <= 7'b1111111;
      end else begin
         r_state     <= w_state_nxt;
         r_div       <= w_div_nxt;
         r_ones_prev <= io_disp.ones_bcd;
         r_tens      <= w_tens_nxt;
         r_carry     <= w_carry_nxt;
         r_an        <= w_an_nxt;
         r_seg       <= w_seg_nxt;
      end
   end

   assign io_disp.tens_bcd  = r_tens;
   assign io_disp.carry_out = r_carry;
   assign io_disp.an        = r_an;
   assign io_disp.seg       = r_seg;

endmodule
